// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: shift opcodes, shift-unit state encoding and default width.
package cpu_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SRL = 2'b01;
    localparam logic [1:0] SH_SRA = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift/rotate of a word, selected by the shift opcode.
module shift_step
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [1:0]       opcode,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    always_comb begin
        dout = din;
        case (opcode)
            SH_SLL: dout = {din[WIDTH-2:0], 1'b0};
            SH_SRL: dout = {1'b0, din[WIDTH-1:1]};
            SH_SRA: dout = {din[WIDTH-1], din[WIDTH-1:1]};
            SH_ROR: dout = {din[0], din[WIDTH-1:1]};
        endcase
    end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/rotate stage: one bit position per clock with a start/busy/done handshake.
module seq_shift_unit
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned AMT_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 START,
    input  logic [1:0]           OPCODE,
    input  logic [WIDTH-1:0]     OPERAND,
    input  logic [AMT_WIDTH-1:0] AMOUNT,
    output logic [WIDTH-1:0]     RESULT,
    output logic                 BUSY,
    output logic                 DONE
);

    localparam int unsigned          CNT_W     = $clog2(WIDTH + 1);
    localparam logic [AMT_WIDTH-1:0] WIDTH_AMT = AMT_WIDTH'(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [1:0]       op_q, op_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] load_cnt;
    logic [WIDTH-1:0] step_out;

    // Linear shifts saturate at WIDTH steps; rotates only need the residue.
    always_comb begin
        if (OPCODE == SH_ROR) begin
            load_cnt = CNT_W'(AMOUNT % WIDTH_AMT);
        end else if (AMOUNT >= WIDTH_AMT) begin
            load_cnt = CNT_W'(WIDTH);
        end else begin
            load_cnt = CNT_W'(AMOUNT);
        end
    end

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .opcode (op_q),
        .din    (work_q),
        .dout   (step_out)
    );

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        result_d = result_q;
        op_d     = op_q;
        count_d  = count_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    work_d  = OPERAND;
                    op_d    = OPCODE;
                    count_d = load_cnt;
                    if (load_cnt == '0) begin
                        state_d  = ST_DONE;
                        result_d = OPERAND;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                work_d  = step_out;
                count_d = count_q - CNT_W'(1);
                // RESULT is only exposed on the final step, never mid-shift.
                if (count_q == CNT_W'(1)) begin
                    state_d  = ST_DONE;
                    result_d = step_out;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q  <= ST_IDLE;
            work_q   <= '0;
            result_q <= '0;
            op_q     <= SH_SLL;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            result_q <= result_d;
            op_q     <= op_d;
            count_q  <= count_d;
        end
    end

    assign RESULT = result_q;
    assign BUSY   = (state_q == ST_SHIFT);
    assign DONE   = (state_q == ST_DONE);

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed scoreboard bench for seq_shift_unit: latency, busy cycles, result and hold behaviour.
module tb_seq_shift_unit;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       START = 1'b0;
    logic [1:0] OPCODE = 2'b00;
    logic [7:0] OPERAND = 8'h00;
    logic [7:0] AMOUNT = 8'h00;
    logic [7:0] RESULT;
    logic       BUSY;
    logic       DONE;

    typedef struct {
        logic [7:0]  res;
        int unsigned lat;
        int unsigned busy;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] held = 8'h00;
    int         pulses;

    seq_shift_unit #(
        .WIDTH     (8),
        .AMT_WIDTH (8)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .START   (START),
        .OPCODE  (OPCODE),
        .OPERAND (OPERAND),
        .AMOUNT  (AMOUNT),
        .RESULT  (RESULT),
        .BUSY    (BUSY),
        .DONE    (DONE)
    );

    always #5 CLK = ~CLK;

    function automatic exp_t model(input logic [1:0] op, input logic [7:0] x,
                                   input logic [7:0] amt);
        exp_t        e;
        int unsigned cnt;
        logic [15:0] dbl;
        dbl = {x, x};
        case (op)
            2'b00: begin
                cnt   = (amt >= 8) ? 8 : int'(amt);
                e.res = (amt >= 8) ? 8'h00 : 8'(x << amt);
            end
            2'b01: begin
                cnt   = (amt >= 8) ? 8 : int'(amt);
                e.res = (amt >= 8) ? 8'h00 : 8'(x >> amt);
            end
            2'b10: begin
                cnt   = (amt >= 8) ? 8 : int'(amt);
                e.res = 8'($signed(x) >>> amt);
            end
            default: begin
                cnt   = int'(amt % 8);
                e.res = 8'(dbl >> cnt);
            end
        endcase
        e.lat  = cnt + 1;
        e.busy = cnt;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; START is sampled at the next rising edge.
    task automatic launch(input logic [1:0] op, input logic [7:0] x, input logic [7:0] amt);
        sb.push_back(model(op, x, amt));
        OPCODE  = op;
        OPERAND = x;
        AMOUNT  = amt;
        START   = 1'b1;
        @(negedge CLK);
        START   = 1'b0;
        OPERAND = ~x;
        AMOUNT  = amt + 8'd3;
    endtask

    task automatic wait_done(input string tag, input int unsigned lat0, input int unsigned busy0);
        exp_t        e;
        int unsigned lat;
        int unsigned busy;
        lat  = lat0;
        busy = busy0;
        while (!DONE && lat < 20) begin
            if (BUSY) busy++;
            check({tag, "_hold_mid"}, 32'(RESULT), 32'(held));
            @(negedge CLK);
            lat++;
        end
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_latency"}, lat, e.lat);
            check({tag, "_busy_cycles"}, busy, e.busy);
            check({tag, "_result"}, 32'(RESULT), 32'(e.res));
            held = e.res;
        end
        @(negedge CLK);
        check({tag, "_done_pulse"}, 32'(DONE), 32'd0);
        check({tag, "_busy_after"}, 32'(BUSY), 32'd0);
        check({tag, "_hold_after"}, 32'(RESULT), 32'(held));
    endtask

    initial begin
        // Power-on reset
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_result", 32'(RESULT), 32'h0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        RESET = 1'b1;
        @(negedge CLK);

        // 1: reset mid-shift aborts without DONE
        launch(2'b11, 8'h81, 8'd5);
        check("t1_busy_inflight", 32'(BUSY), 32'd1);
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        check("t1_rst_result", 32'(RESULT), 32'h0);
        check("t1_rst_busy", 32'(BUSY), 32'd0);
        check("t1_rst_done", 32'(DONE), 32'd0);
        RESET = 1'b1;
        void'(sb.pop_front());
        held   = 8'h00;
        pulses = 0;
        repeat (10) begin
            @(negedge CLK);
            if (DONE) pulses++;
        end
        check("t1_no_done", pulses, 0);

        // 2: arithmetic right shift, also proves START accepted after reset
        launch(2'b10, 8'h96, 8'd3);
        wait_done("t2_sra", 1, 0);
        check("t2_const", 32'(held), 32'hF2);

        // 3: rotate amount wrap
        launch(2'b11, 8'hB4, 8'd10);
        wait_done("t3_ror10", 1, 0);
        check("t3_const", 32'(held), 32'h2D);
        launch(2'b11, 8'hB4, 8'd8);
        wait_done("t3_ror8", 1, 0);
        check("t3b_const", 32'(held), 32'hB4);

        // 4: saturating shifts
        launch(2'b00, 8'hFF, 8'd200);
        wait_done("t4_sll200", 1, 0);
        launch(2'b10, 8'h80, 8'd9);
        wait_done("t4_sra9", 1, 0);
        check("t4_sra_const", 32'(held), 32'hFF);
        launch(2'b01, 8'h80, 8'd8);
        wait_done("t4_srl8", 1, 0);

        // 5: second START while busy is ignored
        launch(2'b01, 8'hF0, 8'd4);
        check("t5_busy", 32'(BUSY), 32'd1);
        OPCODE  = 2'b01;
        OPERAND = 8'h0F;
        AMOUNT  = 8'd1;
        START   = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        wait_done("t5_srl4", 2, 1);
        check("t5_const", 32'(held), 32'h0F);
        pulses = 0;
        repeat (10) begin
            @(negedge CLK);
            if (DONE) pulses++;
        end
        check("t5_no_second_done", pulses, 0);
        check("t5_result_kept", 32'(RESULT), 32'h0F);

        // 6: zero amount then immediate back-to-back START
        launch(2'b00, 8'h5A, 8'd0);
        wait_done("t6_sll0", 1, 0);
        launch(2'b01, 8'h5A, 8'd1);
        wait_done("t6_srl1", 1, 0);
        check("t6_const", 32'(held), 32'h2D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_shift_unit.md
Name: seq_shift_unit

Overview:
- Multi-cycle shift/rotate execution stage for the 8-bit CPU datapath.
- Sits between the register-file read port and the ALU result mux, beside the combinational rotate-right unit.
- Executes the shift-class instructions sll, srl, sra and ror one bit position per clock. Supports shift amounts beyond 7.
- Presents the result with a start/busy/done handshake to the CPU control unit, which stalls the PC while BUSY is high.

Parameters:
- WIDTH, 8, operand/result width in bits.
- AMT_WIDTH, 8, width of the shift-amount field (taken from the instruction immediate).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-low reset.
- START  input  1  one-cycle request from the control unit; sampled only in IDLE.
- OPCODE  input  2  00 sll, 01 srl, 10 sra, 11 ror; sampled with START.
- OPERAND  input  WIDTH  value to shift; sampled with START.
- AMOUNT  input  AMT_WIDTH  shift distance; sampled with START.
- RESULT  output  WIDTH  shifted value; held stable from DONE until the next accepted START.
- BUSY  output  1  high from the cycle after START is accepted until DONE is asserted (inclusive of the SHIFT cycles, exclusive of DONE).
- DONE  output  1  single-cycle pulse; RESULT is valid in this cycle.

Behaviour:
- Reset: RESET low at a rising edge forces:
  - state IDLE, RESULT=0, BUSY=0, DONE=0, internal count=0.
  - Reset applies from any state and aborts an in-flight operation with no DONE.
- States and transitions:
  - IDLE:
    - START=1 latches OPERAND into the working register, latches OPCODE, and loads count.
    - Next state is SHIFT if count≠0, else DONE.
    - START=0 stays in IDLE.
  - SHIFT:
    - Each cycle performs one 1-bit step on the working register and decrements count.
    - When the decremented count is 0, next state is DONE; otherwise remain in SHIFT.
    - START is ignored.
  - DONE:
    - DONE=1 for exactly one cycle; the next state is IDLE unconditionally.
    - START during DONE is ignored; the control unit must re-assert START in IDLE.
- Count load rules:
  - sll/srl/sra: count = min(AMOUNT, WIDTH).
  - ror: count = AMOUNT mod WIDTH, i.e. AMOUNT[2:0] for WIDTH=8.
- 1-bit step rules:
  - sll: {w[6:0],0}
  - srl: {0,w[7:1]}
  - sra: {w[7],w[7:1]}
  - ror: {w[0],w[7:1]}
- Saturation results:
  - sll/srl with AMOUNT≥8 yields 0x00.
  - sra with AMOUNT≥8 yields 0x00 or 0xFF according to the OPERAND sign bit.
- Latency:
  - DONE is asserted count+1 cycles after the START edge.
  - Best case is 1 cycle (count=0); worst case is 9 cycles (count=8).
- Output timing:
  - RESULT updates only on the transition into DONE and holds until the next accepted START, then updates again at that operation's DONE.
  - RESULT is not visible mid-shift.
- BUSY is registered: 1 in SHIFT, 0 in IDLE and DONE.
- Input stability: OPERAND/OPCODE/AMOUNT changes after the START cycle have no effect.
- Throughput: back-to-back operations need one IDLE cycle between DONE and the next START.

Decomposition:
- Shared package cpu_pkg holds:
  - shift opcode constants SH_SLL=2'b00, SH_SRL=2'b01, SH_SRA=2'b10, SH_ROR=2'b11.
  - state encoding ST_IDLE, ST_SHIFT, ST_DONE.
  - WIDTH default 8.
- One natural sub-module, shift_step: a combinational 1-bit shift selected by opcode. It is instantiated once on the working register.
- The FSM and counter stay in seq_shift_unit.

Test Plan:
1. Reset handling: RESET low for 2 cycles mid-SHIFT (ror 0x81 by 5, reset after 2 shift cycles) -> RESULT=0x00, BUSY=0, no DONE pulse; the unit accepts a new START afterwards.
2. Arithmetic right shift: START, sra, OPERAND=0x96, AMOUNT=3 -> BUSY high 3 cycles, DONE on cycle 4 after START, RESULT=0xF2.
3. Rotate amount wrap: START, ror, OPERAND=0xB4, AMOUNT=10 -> count=2, DONE 3 cycles after START, RESULT=0x2D. A second run with AMOUNT=8 -> DONE 1 cycle after START, RESULT=0xB4.
4. Saturating shifts:
   - sll 0xFF by 200 -> DONE after 9 cycles, RESULT=0x00.
   - sra 0x80 by 9 -> RESULT=0xFF.
   - srl 0x80 by 8 -> RESULT=0x00.
5. Ignored START and input changes: START pulsed again while BUSY (srl 0xF0 by 4 in flight, second START with srl 0x0F by 1), OPERAND changed after acceptance -> single DONE, RESULT=0x0F, second request ignored.
6. Zero amount and back-to-back: sll 0x5A by 0 -> DONE 1 cycle after START, RESULT=0x5A, BUSY never high. The next START in the following IDLE cycle (srl 0x5A by 1) -> RESULT=0x2D.
